// File: rtl/row_chi_stage_pkg.sv
// rtl/row_chi_stage_pkg.sv - shared constants, FSM encoding and bit-map helper for the chi stage
package row_chi_stage_pkg;

  localparam int LINE_W  = 25;
  localparam int N_LINES = 64;
  localparam int CNT_W   = 7;
  localparam int ROW_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit position of lane (x,y) inside a 25-bit slice.
  function automatic int chi_idx(input int x, input int y);
    return ROW_W * y + x;
  endfunction

endpackage

// File: rtl/row_chi_stage_chi_row.sv
// rtl/row_chi_stage_chi_row.sv - combinational 5-bit row mix: out[x] = in[x] ^ (~in[x+1] & in[x+2])
module row_chi_stage_chi_row
  import row_chi_stage_pkg::*;
(
  input  logic [ROW_W-1:0] row_in,
  output logic [ROW_W-1:0] row_out
);

  for (genvar x = 0; x < ROW_W; x++) begin : g_lane
    assign row_out[x] = row_in[x] ^ (~row_in[(x + 1) % ROW_W] & row_in[(x + 2) % ROW_W]);
  end

endmodule

// File: rtl/row_chi_stage_ctrl.sv
// rtl/row_chi_stage_ctrl.sv - sequencing FSM: alternates READ/WRITE per line, pulses done after the last line
module row_chi_stage_ctrl
  import row_chi_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic last,
  output logic wr_en,
  output logic inreg_en,
  output logic cnt_en,
  output logic cnt_rst,
  output logic done
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    inreg_en   = 1'b0;
    cnt_en     = 1'b0;
    cnt_rst    = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_rst    = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        inreg_en   = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        // The counter holds at the last line so the address never leaves 0..N_LINES-1.
        if (last) begin
          state_next = ST_DONE;
        end else begin
          cnt_en     = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        cnt_rst    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/row_chi_stage_datapath.sv
// rtl/row_chi_stage_datapath.sv - line counter, input register and five parallel chi row networks
module row_chi_stage_datapath
  import row_chi_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              inreg_en,
  input  logic              cnt_en,
  input  logic              cnt_rst,
  input  logic [LINE_W-1:0] line_in,
  output logic [CNT_W-1:0]  cnt_value,
  output logic              last,
  output logic              write_enable,
  output logic [LINE_W-1:0] write_value
);

  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] inreg;
  logic [LINE_W-1:0] chi_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_rst) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inreg <= '0;
    end else if (inreg_en) begin
      inreg <= line_in;
    end
  end

  for (genvar y = 0; y < ROW_W; y++) begin : g_row
    row_chi_stage_chi_row u_chi_row (
      .row_in  (inreg[chi_idx(0, y) +: ROW_W]),
      .row_out (chi_out[chi_idx(0, y) +: ROW_W])
    );
  end

  assign last         = (cnt == CNT_W'(N_LINES - 1));
  assign cnt_value    = cnt;
  assign write_enable = wr_en;
  // Gate the write data so the bus reads zero whenever no write is in flight.
  assign write_value  = wr_en ? chi_out : '0;

endmodule

// File: rtl/row_chi_stage.sv
// rtl/row_chi_stage.sv - in-place row chi pass over the 64-line state memory, two cycles per line
module row_chi_stage
  import row_chi_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LINE_W-1:0] line_in,
  output logic [CNT_W-1:0]  cnt_value,
  output logic              write_enable,
  output logic [LINE_W-1:0] write_value,
  output logic              done
);

  logic wr_en;
  logic inreg_en;
  logic cnt_en;
  logic cnt_rst;
  logic last;

  row_chi_stage_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .last     (last),
    .wr_en    (wr_en),
    .inreg_en (inreg_en),
    .cnt_en   (cnt_en),
    .cnt_rst  (cnt_rst),
    .done     (done)
  );

  row_chi_stage_datapath u_datapath (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .inreg_en     (inreg_en),
    .cnt_en       (cnt_en),
    .cnt_rst      (cnt_rst),
    .line_in      (line_in),
    .cnt_value    (cnt_value),
    .last         (last),
    .write_enable (write_enable),
    .write_value  (write_value)
  );

endmodule

// File: tb/tb_row_chi_stage.sv
// tb/tb_row_chi_stage.sv - self-checking bench: timeline model of a pass plus directed literal checks
module tb_row_chi_stage;

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] line_in;
  logic [6:0]  cnt_value;
  logic        write_enable;
  logic [24:0] write_value;
  logic        done;

  logic [24:0] mem [64];

  int pass_cnt  = 0;
  int check_cnt = 0;

  row_chi_stage dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .line_in      (line_in),
    .cnt_value    (cnt_value),
    .write_enable (write_enable),
    .write_value  (write_value),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign line_in = mem[cnt_value[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference chi computed bit by bit from the (x,y) rule.
  function automatic logic [24:0] chi_model(input logic [24:0] v);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = v[5*y+x] ^ (~v[5*y+(x+1)%5] & v[5*y+(x+2)%5]);
    return r;
  endfunction

  // Timeline model: t = cycle number within a pass (1..128 lines, 129 = done).
  int cyc     = 0;
  bit started = 0;
  bit busy    = 0;
  int t       = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (rst) begin
      busy = 0;
      t    = 0;
    end else if (busy) begin
      if (t == 129) begin
        busy = 0;
        t    = 0;
      end else begin
        t++;
      end
    end else if (start) begin
      busy = 1;
      t    = 1;
    end
  end

  always @(negedge clk) begin
    logic        e_we;
    logic        e_done;
    logic [6:0]  e_cnt;
    logic [24:0] e_wv;
    if (started) begin
      e_we   = busy && (t <= 128) && (t % 2 == 0);
      e_done = busy && (t == 129);
      e_cnt  = !busy ? 7'd0 : (t <= 128 ? 7'((t - 1) / 2) : 7'd63);
      e_wv   = e_we ? chi_model(mem[(t - 1) / 2]) : 25'd0;
      chk($sformatf("model.write_enable@%0d", cyc), {31'd0, write_enable}, {31'd0, e_we});
      chk($sformatf("model.done@%0d", cyc), {31'd0, done}, {31'd0, e_done});
      chk($sformatf("model.cnt_value@%0d", cyc), {25'd0, cnt_value}, {25'd0, e_cnt});
      chk($sformatf("model.write_value@%0d", cyc), {7'd0, write_value}, {7'd0, e_wv});
    end
  end

  // Capture of DUT writes and done pulses for the directed checks.
  int          s_cyc    = 0;
  int          done_cnt = 0;
  int          done_rel = 0;
  logic [6:0]  wr_addr [$];
  logic [24:0] wr_data [$];

  always @(negedge clk) begin
    if (started && write_enable === 1'b1) begin
      wr_addr.push_back(cnt_value);
      wr_data.push_back(write_value);
    end
    if (started && done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - s_cyc + 1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_capture();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    done_rel = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 s_cyc = cyc;
    #1 start = 1'b0;
  endtask

  // One pass; optional mid-pass start pulses at relative cycles re1/re2; b2b chains a second pass.
  task automatic run_pass(input int re1, input int re2, input bit b2b);
    int rel;
    int n;
    int want;
    bit second;
    want   = b2b ? 2 : 1;
    second = 0;
    n      = 0;
    pulse_start();
    rel = 1;
    while (!(done_cnt >= want && rel >= 130) && n < 400) begin
      cycle();
      n++;
      rel   = cyc - s_cyc + 1;
      start = (rel == re1) || (rel == re2) || (b2b && !second && (rel == 129 || rel == 130));
      if (b2b && !second && rel == 131) begin
        s_cyc  = cyc;
        rel    = 1;
        second = 1;
      end
    end
    start = 1'b0;
    if (n >= 400) chk("pass_timeout", 32'(done_cnt), 32'(want));
  endtask

  initial begin
    logic ok;
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = '0;
    cycle();
    // start coincident with rst must be dropped
    start = 1'b1;
    cycle();
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("reset.cnt_value", {25'd0, cnt_value}, 32'd0);
    chk("reset.write_enable", {31'd0, write_enable}, 32'd0);
    chk("reset.write_value", {7'd0, write_value}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    cycle();

    // 1: all-zero memory
    clear_capture();
    run_pass(0, 0, 0);
    chk("t1.writes", 32'(wr_addr.size()), 32'd64);
    chk("t1.done_count", 32'(done_cnt), 32'd1);
    chk("t1.done_cycle", 32'(done_rel), 32'd129);
    ok = 1;
    for (int k = 0; k < wr_addr.size(); k++)
      if (wr_addr[k] !== 7'(k) || wr_data[k] !== 25'h0) ok = 0;
    chk("t1.addr_data", {31'd0, ok}, 32'd1);

    // 2: all-ones memory
    for (int k = 0; k < 64; k++) mem[k] = 25'h1FFFFFF;
    clear_capture();
    run_pass(0, 0, 0);
    chk("t2.writes", 32'(wr_data.size()), 32'd64);
    ok = 1;
    for (int k = 0; k < wr_data.size(); k++)
      if (wr_data[k] !== 25'h1FFFFFF) ok = 0;
    chk("t2.data", {31'd0, ok}, 32'd1);

    // 3: single lane x=1 in row k%5
    for (int k = 0; k < 64; k++) mem[k] = 25'h0000002 << (5 * (k % 5));
    clear_capture();
    run_pass(0, 0, 0);
    chk("t3.writes", 32'(wr_data.size()), 32'd64);
    if (wr_data.size() == 64) begin
      chk("t3.row0", {7'd0, wr_data[0]}, 32'h0000012);
      chk("t3.row1", {7'd0, wr_data[1]}, 32'h0000240);
      chk("t3.row2", {7'd0, wr_data[2]}, 32'h0004800);
      chk("t3.row3", {7'd0, wr_data[3]}, 32'h0090000);
      chk("t3.row4", {7'd0, wr_data[4]}, 32'h1200000);
      chk("t3.row4_last", {7'd0, wr_data[59]}, 32'h1200000);
    end

    // 4: start re-pulsed mid-pass
    for (int k = 0; k < 64; k++) mem[k] = 25'($urandom);
    clear_capture();
    run_pass(10, 60, 0);
    chk("t4.writes", 32'(wr_addr.size()), 32'd64);
    chk("t4.done_count", 32'(done_cnt), 32'd1);
    chk("t4.done_cycle", 32'(done_rel), 32'd129);

    // 5: reset at cycle 50 of a pass
    clear_capture();
    pulse_start();
    while (cyc - s_cyc + 1 < 50) cycle();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("t5.cnt_value", {25'd0, cnt_value}, 32'd0);
    chk("t5.write_enable", {31'd0, write_enable}, 32'd0);
    chk("t5.done", {31'd0, done}, 32'd0);
    repeat (150) cycle();
    chk("t5.no_done", 32'(done_cnt), 32'd0);
    clear_capture();
    run_pass(0, 0, 0);
    chk("t5.restart_writes", 32'(wr_addr.size()), 32'd64);
    chk("t5.restart_done", 32'(done_cnt), 32'd1);

    // 6: random image, back-to-back passes
    for (int k = 0; k < 64; k++) mem[k] = 25'($urandom);
    clear_capture();
    run_pass(0, 0, 1);
    chk("t6.writes", 32'(wr_addr.size()), 32'd128);
    chk("t6.done_count", 32'(done_cnt), 32'd2);
    chk("t6.done_cycle", 32'(done_rel), 32'd129);

    repeat (3) cycle();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
